// File: rtl/rf_port_arbiter_pkg.sv
// Shared constants and types for the register-file write-port arbiter.
// Imported by the arbiter top and its one-hot decoder.
package rf_port_arbiter_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rf_port_arbiter_decoder.sv
// 3-to-8 one-hot decoder with enable.
// Drives the per-source write-data mux select.
module Decoder_3_8
    import rf_port_arbiter_pkg::*;
(
    input  logic [IDX_W-1:0]   in_i,
    input  logic               en_i,
    output logic [NUM_REQ-1:0] out_o
);

    always_comb begin
        out_o = '0;
        if (en_i) begin
            out_o[in_i] = 1'b1;
        end
    end

endmodule

// File: rtl/rf_port_arbiter.sv
// Round-robin owner arbiter for the single register-file write port.
// A grant is held until release, request drop, or the hold limit.
module rf_port_arbiter
    import rf_port_arbiter_pkg::*;
#(
    parameter int MAX_HOLD = 16,
    parameter int HOLD_W   = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_i,
    input  logic               release_i,
    output logic               grant_valid_o,
    output logic [IDX_W-1:0]   grant_idx_o,
    output logic [NUM_REQ-1:0] grant_o,
    output logic               timeout_o
);

    arb_state_e        state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic              tout_q, tout_d;

    logic end_rel;
    logic end_drop;
    logic end_hold;

    // Lowest offset from the pointer wins, so scan from the far end down.
    function automatic logic [IDX_W-1:0] rr_pick(
        input logic [NUM_REQ-1:0] r,
        input logic [IDX_W-1:0]   p
    );
        logic [IDX_W-1:0] k;
        rr_pick = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            k = p + IDX_W'(i);
            if (r[k]) begin
                rr_pick = k;
            end
        end
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            ptr_q   <= '0;
            hold_q  <= '0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            ptr_q   <= ptr_d;
            hold_q  <= hold_d;
            tout_q  <= tout_d;
        end
    end

    assign end_rel  = release_i;
    assign end_drop = ~req_i[idx_q];
    assign end_hold = (MAX_HOLD != 0) &&
                      (hold_q == HOLD_W'(MAX_HOLD - 1));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        ptr_d   = ptr_q;
        hold_d  = hold_q;
        tout_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|req_i) begin
                    state_d = BUSY;
                    idx_d   = rr_pick(req_i, ptr_q);
                    hold_d  = '0;
                end
            end
            BUSY: begin
                if (end_rel || end_drop || end_hold) begin
                    state_d = IDLE;
                    idx_d   = '0;
                    ptr_d   = idx_q + 1'b1;
                    hold_d  = '0;
                    tout_d  = end_hold && !end_rel && !end_drop;
                end else if (hold_q != '1) begin
                    hold_d = hold_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        grant_valid_o = (state_q == BUSY);
        grant_idx_o   = idx_q;
        timeout_o     = tout_q;
    end

    Decoder_3_8 u_dec (
        .in_i  (idx_q),
        .en_i  (state_q == BUSY),
        .out_o (grant_o)
    );

endmodule

// File: tb/tb_rf_port_arbiter.sv
// Directed scoreboard bench for rf_port_arbiter (MAX_HOLD=4).
// Stimulus pushes expected outputs; a monitor pops and compares.
module tb_rf_port_arbiter;

    logic       clk;
    logic       rst;
    logic [7:0] req;
    logic       rel;
    logic       gv;
    logic [2:0] gidx;
    logic [7:0] gnt;
    logic       tout;

    typedef struct {
        int         id;
        logic       v;
        logic [2:0] idx;
        logic [7:0] g;
        logic       t;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_step = 0;

    rf_port_arbiter #(
        .MAX_HOLD (4),
        .HOLD_W   (8)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .req_i         (req),
        .release_i     (rel),
        .grant_valid_o (gv),
        .grant_idx_o   (gidx),
        .grant_o       (gnt),
        .timeout_o     (tout)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n_chk++;
            if (gv !== e.v || gidx !== e.idx ||
                gnt !== e.g || tout !== e.t) begin
                n_fail++;
                $display("FAIL step%0d got v=%b idx=%0d g=%h t=%b exp v=%b idx=%0d g=%h t=%b",
                         e.id, gv, gidx, gnt, tout,
                         e.v, e.idx, e.g, e.t);
            end
        end
    end

    task automatic step(
        input logic       r,
        input logic [7:0] rq,
        input logic       rl,
        input logic       ev,
        input logic [2:0] ei,
        input logic [7:0] eg,
        input logic       et
    );
        exp_t e;
        @(negedge clk);
        rst = r;
        req = rq;
        rel = rl;
        e.id  = n_step;
        e.v   = ev;
        e.idx = ei;
        e.g   = eg;
        e.t   = et;
        exp_q.push_back(e);
        n_step++;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 8'h00;
        rel = 1'b0;

        // reset / idle
        step(1, 8'h00, 0, 0, 0, 8'h00, 0);
        step(1, 8'h00, 0, 0, 0, 8'h00, 0);

        // single request, release on third granted cycle
        step(0, 8'h08, 0, 1, 3, 8'h08, 0);
        step(0, 8'h08, 0, 1, 3, 8'h08, 0);
        step(0, 8'h08, 0, 1, 3, 8'h08, 0);
        step(0, 8'h08, 1, 0, 0, 8'h00, 0);
        // ptr=4 picks 4 over 3
        step(0, 8'h18, 0, 1, 4, 8'h10, 0);
        step(0, 8'h18, 1, 0, 0, 8'h00, 0);
        // ptr=5 wraps to 3
        step(0, 8'h18, 0, 1, 3, 8'h08, 0);
        step(0, 8'h00, 0, 0, 0, 8'h00, 0);
        // release in idle ignored
        step(0, 8'h00, 1, 0, 0, 8'h00, 0);

        // round robin with wrap from reset
        step(1, 8'h00, 0, 0, 0, 8'h00, 0);
        step(0, 8'h81, 0, 1, 0, 8'h01, 0);
        step(0, 8'h81, 1, 0, 0, 8'h00, 0);
        step(0, 8'h81, 0, 1, 7, 8'h80, 0);
        step(0, 8'h81, 1, 0, 0, 8'h00, 0);
        step(0, 8'h81, 0, 1, 0, 8'h01, 0);
        step(0, 8'h81, 1, 0, 0, 8'h00, 0);
        step(0, 8'h81, 0, 1, 7, 8'h80, 0);
        step(0, 8'h81, 1, 0, 0, 8'h00, 0);
        // release held high: 1-cycle rotating grants
        step(0, 8'h81, 1, 1, 0, 8'h01, 0);
        step(0, 8'h81, 1, 0, 0, 8'h00, 0);
        step(0, 8'h81, 1, 1, 7, 8'h80, 0);
        step(0, 8'h00, 1, 0, 0, 8'h00, 0);

        // timeout after 4 cycles, regrant after one idle
        step(0, 8'h02, 0, 1, 1, 8'h02, 0);
        step(0, 8'h02, 0, 1, 1, 8'h02, 0);
        step(0, 8'h02, 0, 1, 1, 8'h02, 0);
        step(0, 8'h02, 0, 1, 1, 8'h02, 0);
        step(0, 8'h02, 0, 0, 0, 8'h00, 1);
        step(0, 8'h02, 0, 1, 1, 8'h02, 0);
        step(0, 8'h00, 0, 0, 0, 8'h00, 0);

        // owner 5 drops request; busy-time changes ignored
        step(0, 8'h20, 0, 1, 5, 8'h20, 0);
        step(0, 8'h27, 0, 1, 5, 8'h20, 0);
        step(0, 8'h07, 0, 0, 0, 8'h00, 0);
        step(0, 8'h07, 0, 1, 0, 8'h01, 0);
        step(0, 8'h00, 0, 0, 0, 8'h00, 0);

        // reset mid-grant clears pointer
        step(0, 8'h40, 0, 1, 6, 8'h40, 0);
        step(0, 8'hC1, 0, 1, 6, 8'h40, 0);
        step(1, 8'hC1, 0, 0, 0, 8'h00, 0);
        step(0, 8'hC1, 0, 1, 0, 8'h01, 0);
        step(0, 8'hC1, 1, 0, 0, 8'h00, 0);
        step(0, 8'hC1, 0, 1, 6, 8'h40, 0);
        step(0, 8'h00, 0, 0, 0, 8'h00, 0);

        // release wins over hold limit: no timeout pulse
        step(0, 8'h02, 0, 1, 1, 8'h02, 0);
        step(0, 8'h02, 0, 1, 1, 8'h02, 0);
        step(0, 8'h02, 0, 1, 1, 8'h02, 0);
        step(0, 8'h02, 0, 1, 1, 8'h02, 0);
        step(0, 8'h02, 1, 0, 0, 8'h00, 0);
        step(0, 8'h00, 0, 0, 0, 8'h00, 0);

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
            @(posedge clk);
            #2;
        end
        if (exp_q.size() > 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL drain got %0d pending exp 0",
                     exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
